// File: rtl/ga_run_sequencer.sv
// Generation scheduler for the GA engine: drives init/eval/breed/mutate stages through
// start/done handshakes, hands out xorshift32 seeds, tracks best fitness and guards each stage.
module ga_run_sequencer #(
  parameter int unsigned GEN_W   = 16,
  parameter int unsigned FIT_W   = 16,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [GEN_W-1:0] max_gen,
  input  logic [FIT_W-1:0] fit_target,
  input  logic [31:0]      prg_seed,
  output logic             init_start,
  input  logic             init_done,
  output logic             eval_start,
  input  logic             eval_done,
  input  logic [FIT_W-1:0] eval_best,
  output logic             breed_start,
  input  logic             breed_done,
  output logic             mut_start,
  input  logic             mut_done,
  output logic [31:0]      stage_seed,
  output logic [GEN_W-1:0] gen_count,
  output logic [FIT_W-1:0] best_fit,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StEval,
    StCheck,
    StBreed,
    StMutate,
    StFin,
    StFail
  } state_e;

  state_e           state_q;
  logic [GEN_W-1:0] max_gen_q;
  logic [FIT_W-1:0] fit_target_q;
  logic [WdW-1:0]   wd_q;
  logic             init_done_q;
  logic             eval_done_q;
  logic             breed_done_q;
  logic             mut_done_q;

  logic             stage_rise;
  logic             in_stage;
  logic             wd_expired;
  logic [31:0]      seed_next;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  assign seed_next = xorshift32(stage_seed);

  // Completion only on a fresh rising edge of the running stage's done, never in its pulse cycle,
  // so a level left high by an earlier transaction cannot finish a new stage.
  always_comb begin
    stage_rise = 1'b0;
    in_stage   = 1'b1;
    case (state_q)
      StInit:   stage_rise = init_done  & ~init_done_q  & ~init_start;
      StEval:   stage_rise = eval_done  & ~eval_done_q  & ~eval_start;
      StBreed:  stage_rise = breed_done & ~breed_done_q & ~breed_start;
      StMutate: stage_rise = mut_done   & ~mut_done_q   & ~mut_start;
      default:  in_stage   = 1'b0;
    endcase
  end

  assign wd_expired = in_stage && (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      max_gen_q    <= '0;
      fit_target_q <= '0;
      wd_q         <= '0;
      init_done_q  <= 1'b0;
      eval_done_q  <= 1'b0;
      breed_done_q <= 1'b0;
      mut_done_q   <= 1'b0;
      init_start   <= 1'b0;
      eval_start   <= 1'b0;
      breed_start  <= 1'b0;
      mut_start    <= 1'b0;
      stage_seed   <= '0;
      gen_count    <= '0;
      best_fit     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      init_done_q  <= init_done;
      eval_done_q  <= eval_done;
      breed_done_q <= breed_done;
      mut_done_q   <= mut_done;
      init_start   <= 1'b0;
      eval_start   <= 1'b0;
      breed_start  <= 1'b0;
      mut_start    <= 1'b0;
      if (in_stage) begin
        wd_q <= wd_q + WdW'(1);
      end

      case (state_q)
        StIdle, StFin, StFail: begin
          if (start) begin
            max_gen_q    <= max_gen;
            fit_target_q <= fit_target;
            stage_seed   <= (prg_seed == 32'h0) ? 32'h1 : prg_seed;
            gen_count    <= '0;
            best_fit     <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            init_start   <= 1'b1;
            wd_q         <= '0;
            state_q      <= StInit;
          end
        end

        StInit: begin
          if (stage_rise) begin
            eval_start <= 1'b1;
            stage_seed <= seed_next;
            wd_q       <= '0;
            state_q    <= StEval;
          end else if (wd_expired) begin
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= StFail;
          end
        end

        StEval: begin
          if (stage_rise) begin
            if (eval_best > best_fit) begin
              best_fit <= eval_best;
            end
            state_q <= StCheck;
          end else if (wd_expired) begin
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= StFail;
          end
        end

        StCheck: begin
          if ((best_fit >= fit_target_q) || (gen_count == max_gen_q)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StFin;
          end else begin
            breed_start <= 1'b1;
            stage_seed  <= seed_next;
            wd_q        <= '0;
            state_q     <= StBreed;
          end
        end

        StBreed: begin
          if (stage_rise) begin
            mut_start  <= 1'b1;
            stage_seed <= seed_next;
            wd_q       <= '0;
            state_q    <= StMutate;
          end else if (wd_expired) begin
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= StFail;
          end
        end

        StMutate: begin
          if (stage_rise) begin
            gen_count  <= gen_count + GEN_W'(1);
            eval_start <= 1'b1;
            stage_seed <= seed_next;
            wd_q       <= '0;
            state_q    <= StEval;
          end else if (wd_expired) begin
            busy    <= 1'b0;
            error   <= 1'b1;
            state_q <= StFail;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ga_run_sequencer.sv
// Bench for ga_run_sequencer: stage responders, a run-level model of the pulse order and seed
// chain, and directed scenarios with literal expectations.
module tb_ga_run_sequencer;

  localparam int unsigned GEN_W   = 16;
  localparam int unsigned FIT_W   = 16;
  localparam int unsigned TIMEOUT = 50;
  localparam int          DLY     = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [GEN_W-1:0] max_gen;
  logic [FIT_W-1:0] fit_target;
  logic [31:0]      prg_seed;
  logic             init_start, eval_start, breed_start, mut_start;
  logic             init_done, eval_done, breed_done, mut_done;
  logic [FIT_W-1:0] eval_best;
  logic [31:0]      stage_seed;
  logic [GEN_W-1:0] gen_count;
  logic [FIT_W-1:0] best_fit;
  logic             busy, done, error;

  always #5 clk = ~clk;

  ga_run_sequencer #(
    .GEN_W   (GEN_W),
    .FIT_W   (FIT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .max_gen     (max_gen),
    .fit_target  (fit_target),
    .prg_seed    (prg_seed),
    .init_start  (init_start),
    .init_done   (init_done),
    .eval_start  (eval_start),
    .eval_done   (eval_done),
    .eval_best   (eval_best),
    .breed_start (breed_start),
    .breed_done  (breed_done),
    .mut_start   (mut_start),
    .mut_done    (mut_done),
    .stage_seed  (stage_seed),
    .gen_count   (gen_count),
    .best_fit    (best_fit),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared bench state
  logic [FIT_W-1:0] ev[16];
  int               eval_idx = 0;
  bit               breed_en = 1'b1;
  bit               init_hold = 1'b0;
  bit               init_retrig = 1'b0;
  byte              exp_q[$];
  logic [31:0]      seed_log[$];
  logic [31:0]      run_seed = 32'h1;
  int               exp_gen, exp_best;
  int               pulses_seen = 0;
  int               breed_cyc = 0;
  int               err_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Run-level model: stage order and final counters from the generation loop rules.
  task automatic build_model(input int mg, input int tgt, input bit hang);
    int g, best, k;
    exp_q.delete();
    g = 0; best = 0; k = 0;
    exp_q.push_back("I");
    exp_q.push_back("E");
    if (int'(ev[k]) > best) best = int'(ev[k]);
    k++;
    while (!(best >= tgt || g == mg)) begin
      exp_q.push_back("B");
      if (hang) break;
      exp_q.push_back("M");
      g++;
      exp_q.push_back("E");
      if (int'(ev[k]) > best) best = int'(ev[k]);
      k++;
    end
    exp_gen = g;
    exp_best = best;
  endtask

  // Stage responders: done pulses for one cycle DLY cycles after each start pulse.
  initial begin : responder
    int ic, ec, bc, mc;
    ic = -1; ec = -1; bc = -1; mc = -1;
    init_done = 1'b0; eval_done = 1'b0; breed_done = 1'b0; mut_done = 1'b0;
    eval_best = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ic = -1; ec = -1; bc = -1; mc = -1;
        init_done = 1'b0; eval_done = 1'b0; breed_done = 1'b0; mut_done = 1'b0;
      end else begin
        ic = (ic > 0) ? ic - 1 : -1;
        ec = (ec > 0) ? ec - 1 : -1;
        bc = (bc > 0) ? bc - 1 : -1;
        mc = (mc > 0) ? mc - 1 : -1;
        if (init_start) ic = DLY;
        if (eval_start) ec = DLY;
        if (breed_start && breed_en) bc = DLY;
        if (mut_start) mc = DLY;
        if (init_retrig) begin
          ic = 2;
          init_retrig = 1'b0;
        end
        init_done  = init_hold | (ic == 0);
        eval_done  = (ec == 0);
        breed_done = (bc == 0);
        mut_done   = (mc == 0);
        if (ec == 0) begin
          eval_best = ev[eval_idx];
          eval_idx++;
        end
      end
    end
  end

  // Compare process: every start pulse against the model's order and seed chain.
  initial begin : compare
    int  np, m_seen;
    byte k;
    logic [31:0] model_seed;
    bit  err_prev;
    m_seen = 0; model_seed = '0; err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        np = int'(init_start) + int'(eval_start) + int'(breed_start) + int'(mut_start);
        if (np > 0) begin
          check("one_pulse", np, 1);
          k = init_start ? "I" : eval_start ? "E" : breed_start ? "B" : "M";
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_pulse: got %c, expected none (t=%0t)", k, $time);
          end else begin
            check("pulse_kind", k, exp_q.pop_front());
          end
          if (k == "I") begin
            model_seed = run_seed;
            m_seen = 0;
            pulses_seen = 0;
          end else begin
            model_seed = xs(model_seed);
          end
          check("stage_seed", stage_seed, model_seed);
          seed_log.push_back(stage_seed);
          if (k == "E") check("gen_at_eval", gen_count, m_seen);
          if (k == "M") m_seen++;
          if (k == "B") breed_cyc = cyc;
          pulses_seen++;
        end
        if (busy) check("busy_excl", {done, error}, 0);
        if (error && !err_prev) err_cyc = cyc;
        err_prev = error;
      end else begin
        err_prev = 1'b0;
      end
    end
  end

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {init_start, eval_start, breed_start, mut_start, busy, done, error}, 0);
    check({name, "_seed"}, stage_seed, 0);
    check({name, "_gen"}, gen_count, 0);
    check({name, "_best"}, best_fit, 0);
  endtask

  task automatic clear_ev();
    for (int i = 0; i < 16; i++) ev[i] = '0;
  endtask

  task automatic start_run(input logic [31:0] seed, input int mg, input int tgt, input bit hang);
    build_model(mg, tgt, hang);
    seed_log.delete();
    eval_idx = 0;
    run_seed = (seed == 32'h0) ? 32'h1 : seed;
    @(negedge clk);
    prg_seed = seed;
    max_gen = GEN_W'(mg);
    fit_target = FIT_W'(tgt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ends"}, busy, 0);
  endtask

  task automatic final_checks(input string name, input bit hang);
    check({name, "_done"}, done, !hang);
    check({name, "_error"}, error, hang);
    check({name, "_gen"}, gen_count, exp_gen);
    check({name, "_best"}, best_fit, exp_best);
    check({name, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic run(input string name, input logic [31:0] seed, input int mg, input int tgt,
                     input bit hang);
    start_run(seed, mg, tgt, hang);
    wait_idle(name);
    final_checks(name, hang);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0; start = 1'b0; prg_seed = '0; max_gen = '0; fit_target = '0;
    clear_ev();
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single evaluation, max_gen = 0
    clear_ev();
    ev[0] = 16'h0010;
    run("a", 32'h1, 0, 16'hFFFF, 1'b0);
    check("a_init_seed", seed_log[0], 32'h1);
    check("a_eval_seed", seed_log[1], 32'h0004_2021);
    check("a_npulse", seed_log.size(), 2);
    check("a_gen_lit", gen_count, 0);
    check("a_best_lit", best_fit, 16'h0010);

    // Three full generations
    clear_ev();
    ev[0] = 16'd5; ev[1] = 16'd9; ev[2] = 16'd7; ev[3] = 16'd2;
    run("b", 32'hDEAD_BEEF, 3, 16'hFFFF, 1'b0);
    check("b_gen_lit", gen_count, 3);
    check("b_best_lit", best_fit, 9);
    check("b_npulse", seed_log.size(), 11);

    // Early stop on fitness target
    clear_ev();
    ev[0] = 16'd40; ev[1] = 16'd100; ev[2] = 16'd200;
    run("c", 32'h1234_5678, 10, 100, 1'b0);
    check("c_gen_lit", gen_count, 1);
    check("c_npulse", seed_log.size(), 5);

    // Zero seed replaced by 1; fit_target 0 stops after the first eval
    clear_ev();
    ev[0] = 16'd0;
    run("z", 32'h0, 4, 0, 1'b0);
    check("z_init_seed", seed_log[0], 32'h1);
    check("z_npulse", seed_log.size(), 2);

    // init_done stuck high before start, plus a start while busy
    clear_ev();
    ev[0] = 16'd7; ev[1] = 16'd8; ev[2] = 16'd9;
    init_hold = 1'b1;
    repeat (3) @(negedge clk);
    start_run(32'hCAFE, 2, 16'hFFFF, 1'b0);
    repeat (12) @(negedge clk);
    check("s_no_eval", pulses_seen, 1);
    check("s_busy", busy, 1);
    start = 1'b1; max_gen = '0; prg_seed = 32'h5555; fit_target = '0;
    @(negedge clk);
    start = 1'b0;
    init_hold = 1'b0;
    @(negedge clk);
    init_retrig = 1'b1;
    wait_idle("s");
    final_checks("s", 1'b0);
    check("s_gen_lit", gen_count, 2);
    check("s_best_lit", best_fit, 9);

    // Breeder hang -> watchdog error, then a fresh start relaunches
    clear_ev();
    ev[0] = 16'd3; ev[1] = 16'd4;
    breed_en = 1'b0;
    run("t", 32'hABCD_0001, 5, 16'hFFFF, 1'b1);
    check("t_err_latency", err_cyc - breed_cyc, TIMEOUT);
    check("t_busy", busy, 0);
    breed_en = 1'b1;
    run("r", 32'hABCD_0002, 1, 16'hFFFF, 1'b0);
    check("r_best_lit", best_fit, 4);

    // Reset in the middle of BREED
    clear_ev();
    ev[0] = 16'd1;
    breed_en = 1'b0;
    start_run(32'h77, 3, 16'hFFFF, 1'b1);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("m_reached_breed", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("m_reset");
    @(negedge clk);
    rst_n = 1'b1;
    breed_en = 1'b1;
    pulses_seen = 0;
    repeat (20) @(negedge clk);
    check("m_no_pulses", pulses_seen, 0);
    check("m_idle", {busy, done, error}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
